// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-only data memory: sub-word stores become
// read-modify-write pairs, sub-word loads are lane-selected and extended.
module lsu_dmem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_fault,
    output logic                  o_dmem_st,
    output logic                  o_dmem_ld,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_data,
    input  logic [DATA_WIDTH-1:0] i_dmem_data
);

    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW_RD,
        RMW_WR,
        FAULT
    } state_t;

    state_t                  state_reg, state_next;
    logic                    we_reg;
    logic [2:0]              funct3_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   merge_reg;
    logic                    resp_valid_reg, resp_valid_next;
    logic                    resp_fault_reg, resp_fault_next;
    logic [DATA_WIDTH-1:0]   resp_rdata_reg, resp_rdata_next;

    logic                    accept;
    logic                    req_fault;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [ADDR_WIDTH-1:0]   word_addr;

    // Legality and alignment are judged on the live request so the FSM can branch at acceptance.
    always_comb begin
        req_fault = 1'b0;
        if (i_req_we) begin
            if (i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11)) begin
                req_fault = 1'b1;
            end
        end else if ((i_req_funct3 == 3'b110) || (i_req_funct3[1:0] == 2'b11)) begin
            req_fault = 1'b1;
        end
        case (i_req_funct3[1:0])
            2'b01:   if (i_req_addr[0])      req_fault = 1'b1;
            2'b10:   if (|i_req_addr[1:0])   req_fault = 1'b1;
            default: ;
        endcase
    end

    assign word_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
    assign load_byte = i_dmem_data[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = i_dmem_data[{addr_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
            default: load_ext = i_dmem_data;
        endcase
    end

    // Each byte lane either keeps the word read back in RMW_RD or takes the store data.
    // Halfword stores feed wdata[15:8] into the odd lane of the selected half.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = (funct3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == LANE)
                                                    : (addr_reg[1] == LANE[1]);
            assign src = (funct3_reg[0] && LANE[0]) ? wdata_reg[15:8] : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = hit ? src : merge_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        resp_valid_next = 1'b0;
        resp_fault_next = 1'b0;
        resp_rdata_next = '0;
        accept          = 1'b0;
        o_req_ready     = 1'b0;
        o_dmem_st       = 1'b0;
        o_dmem_ld       = 1'b0;
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    accept = 1'b1;
                    if (req_fault) begin
                        state_next = FAULT;
                    end else if (!i_req_we) begin
                        state_next = LD;
                    end else if (i_req_funct3[1:0] == 2'b10) begin
                        state_next = ST;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LD: begin
                o_dmem_ld       = 1'b1;
                o_dmem_addr     = word_addr;
                resp_valid_next = 1'b1;
                resp_rdata_next = load_ext;
                state_next      = IDLE;
            end
            ST: begin
                o_dmem_st       = 1'b1;
                o_dmem_addr     = word_addr;
                o_dmem_data     = wdata_reg;
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            RMW_RD: begin
                o_dmem_ld   = 1'b1;
                o_dmem_addr = word_addr;
                state_next  = RMW_WR;
            end
            RMW_WR: begin
                o_dmem_st       = 1'b1;
                o_dmem_addr     = word_addr;
                o_dmem_data     = merged_word;
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            FAULT: begin
                resp_valid_next = 1'b1;
                resp_fault_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            funct3_reg     <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            merge_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            resp_valid_reg <= resp_valid_next;
            resp_fault_reg <= resp_fault_next;
            resp_rdata_reg <= resp_rdata_next;
            if (accept) begin
                we_reg     <= i_req_we;
                funct3_reg <= i_req_funct3;
                addr_reg   <= i_req_addr;
                wdata_reg  <= i_req_wdata;
            end
            if (state_reg == RMW_RD) begin
                merge_reg <= i_dmem_data;
            end
        end
    end

    assign o_resp_valid = resp_valid_reg;
    assign o_resp_fault = resp_fault_reg;
    assign o_resp_rdata = resp_rdata_reg;

    // we_reg is kept for visibility of the latched request; the state already encodes direction.
    logic unused_we;
    assign unused_we = we_reg;

endmodule
